arb_nx1_fifo: RTL and testbench

ARB_NX1_FIFO -- requirements
Module: arb_nx1_fifo

---
 rtl/arb_nx1_fifo_if.sv | 17 +
 rtl/arb_nx1_fifo.sv | 87 ++++++++
 tb/tb_arb_nx1_fifo.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/arb_nx1_fifo_if.sv
// arb_nx1_fifo_if: byte-channel inputs and arbitrated output bus of arb_nx1_fifo.
interface arb_nx1_fifo_if #(
    parameter int NCH = 2,
    parameter int DW  = 8
);
    logic [NCH*DW-1:0] din;
    logic [NCH-1:0]    dinv;
    logic              obusy;
    logic              ovfclr;
    logic [DW-1:0]     od;
    logic              odv;
    logic [2:0]        ochan;
    logic [NCH-1:0]    ovf;
    logic [NCH-1:0]    empty;
    modport master (output din, dinv, obusy, ovfclr, input od, odv, ochan, ovf, empty);
    modport slave  (input din, dinv, obusy, ovfclr, output od, odv, ochan, ovf, empty);
endinterface

// File: rtl/arb_nx1_fifo.sv
// arb_nx1_fifo: NCH per-channel byte FIFOs merged onto one output by fixed or round-robin grant.
module arb_nx1_fifo #(
    parameter int NCH   = 2,
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int MODE  = 1
) (
    input logic         clk,
    input logic         reset,
    arb_nx1_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = $clog2(NCH);
    logic [DW-1:0]  mem_q [NCH][DEPTH];
    logic [AW-1:0]  wp_q [NCH];
    logic [AW-1:0]  rp_q [NCH];
    logic [CW-1:0]  cnt_q [NCH];
    logic [CW-1:0]  cnt_d [NCH];
    logic [NCH-1:0] ovf_q, ovf_d, wr, rd;
    logic [IW-1:0]  last_q, base, gnt;
    logic           gv, pop;
    logic [DW-1:0]  od_q;
    logic           odv_q;
    logic [2:0]     ochan_q;
    // Fixed priority is round-robin that always restarts after the top channel.
    assign base = MODE == 1 ? last_q : IW'(NCH - 1);
    always_comb begin
        gnt = '0;
        gv  = 1'b0;
        for (int k = 1; k <= NCH; k++)
            if (!gv && cnt_q[(int'(base) + k) % NCH] != '0) begin
                gv  = 1'b1;
                gnt = IW'((int'(base) + k) % NCH);
            end
        pop = gv && !bus.obusy;
        wr  = '0;
        rd  = '0;
        for (int i = 0; i < NCH; i++) begin
            wr[i]    = bus.dinv[i] && cnt_q[i] != CW'(DEPTH);
            rd[i]    = pop && gnt == IW'(i);
            cnt_d[i] = cnt_q[i] + CW'(wr[i]) - CW'(rd[i]);
            ovf_d[i] = (bus.dinv[i] && !wr[i]) || (ovf_q[i] && !bus.ovfclr);
        end
    end
    always_ff @(posedge clk)
        for (int i = 0; i < NCH; i++)
            if (wr[i]) mem_q[i][wp_q[i]] <= bus.din[i*DW +: DW];
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            ovf_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                wp_q[i]  <= '0;
                rp_q[i]  <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            ovf_q <= ovf_d;
            for (int i = 0; i < NCH; i++) begin
                if (wr[i]) wp_q[i] <= wp_q[i] + AW'(1);
                if (rd[i]) rp_q[i] <= rp_q[i] + AW'(1);
                cnt_q[i] <= cnt_d[i];
            end
        end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            od_q    <= '0;
            odv_q   <= 1'b0;
            ochan_q <= '0;
            last_q  <= IW'(NCH - 1);
        end else begin
            odv_q <= pop;
            if (pop) begin
                od_q    <= mem_q[gnt][rp_q[gnt]];
                ochan_q <= 3'(gnt);
                last_q  <= gnt;
            end
        end
    always_comb begin
        bus.empty = '0;
        for (int i = 0; i < NCH; i++) bus.empty[i] = cnt_q[i] == '0;
    end
    assign bus.od    = od_q;
    assign bus.odv   = odv_q;
    assign bus.ochan = ochan_q;
    assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_arb_nx1_fifo.sv
// tb_arb_nx1_fifo: MODE=0 and MODE=1 instances on shared stimulus, checked against a queue model.
module tb_arb_nx1_fifo;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] din = '0;
    logic [1:0]  dinv = '0;
    logic        obusy = 1'b0;
    logic        ovfclr = 1'b0;
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;
    arb_nx1_fifo_if #(.NCH(2), .DW(8)) b0 ();
    arb_nx1_fifo_if #(.NCH(2), .DW(8)) b1 ();
    assign b0.din = din;
    assign b0.dinv = dinv;
    assign b0.obusy = obusy;
    assign b0.ovfclr = ovfclr;
    assign b1.din = din;
    assign b1.dinv = dinv;
    assign b1.obusy = obusy;
    assign b1.ovfclr = ovfclr;
    arb_nx1_fifo #(.NCH(2), .DW(8), .DEPTH(4), .MODE(0)) u0 (.clk(clk), .reset(reset), .bus(b0));
    arb_nx1_fifo #(.NCH(2), .DW(8), .DEPTH(4), .MODE(1)) u1 (.clk(clk), .reset(reset), .bus(b1));

    logic [7:0] mq [2][2][$];
    logic [7:0] m_od [2];
    int         m_ochan [2];
    logic       m_odv [2];
    logic [1:0] m_ovf [2];
    int         m_last [2];

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", n, got, exp, $time);
        end
    endtask

    task automatic step();
        int g;
        int j;
        int s [2];
        for (int m = 0; m < 2; m++) begin
            if (reset) begin
                mq[m][0].delete();
                mq[m][1].delete();
                m_od[m] = '0;
                m_ochan[m] = 0;
                m_odv[m] = 1'b0;
                m_ovf[m] = '0;
                m_last[m] = 1;
            end else begin
                s[0] = mq[m][0].size();
                s[1] = mq[m][1].size();
                g = -1;
                if (!obusy)
                    for (int k = 1; k <= 2; k++) begin
                        j = (m == 1) ? (m_last[m] + k) % 2 : k - 1;
                        if (g < 0 && s[j] > 0) g = j;
                    end
                m_odv[m] = g >= 0;
                if (g >= 0) begin
                    m_od[m] = mq[m][g].pop_front();
                    m_ochan[m] = g;
                    m_last[m] = g;
                end
                if (ovfclr) m_ovf[m] = '0;
                for (int c = 0; c < 2; c++)
                    if (dinv[c]) begin
                        if (s[c] < 4) mq[m][c].push_back(din[c*8 +: 8]);
                        else m_ovf[m][c] = 1'b1;
                    end
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        step();
    end

    initial begin
        @(negedge clk);
        forever begin
            for (int m = 0; m < 2; m++) begin
                chk($sformatf("m%0d_odv", m), 32'(m == 0 ? b0.odv : b1.odv), 32'(m_odv[m]));
                chk($sformatf("m%0d_od", m), 32'(m == 0 ? b0.od : b1.od), 32'(m_od[m]));
                chk($sformatf("m%0d_ochan", m), 32'(m == 0 ? b0.ochan : b1.ochan), 32'(m_ochan[m]));
                chk($sformatf("m%0d_ovf", m), 32'(m == 0 ? b0.ovf : b1.ovf), 32'(m_ovf[m]));
                chk($sformatf("m%0d_empty", m), 32'(m == 0 ? b0.empty : b1.empty),
                    32'({mq[m][1].size() == 0, mq[m][0].size() == 0}));
            end
            @(negedge clk);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        dinv = '0;
        obusy = 1'b0;
        ovfclr = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("rst_odv", 32'(b1.odv), 0);
        chk("rst_empty", 32'(b1.empty), 3);
        chk("rst_ovf", 32'(b1.ovf), 0);
        chk("rst_od", 32'(b1.od), 0);
        chk("rst_ochan", 32'(b1.ochan), 0);
        din = 16'h6141;
        dinv = 2'b11;
        tick();
        dinv = '0;
        tick();
        chk("rr_first_odv", 32'(b1.odv), 1);
        chk("rr_first_od", 32'(b1.od), 32'h41);
        chk("rr_first_ochan", 32'(b1.ochan), 0);
        tick();
        chk("rr_second_odv", 32'(b1.odv), 1);
        chk("rr_second_od", 32'(b1.od), 32'h61);
        chk("rr_second_ochan", 32'(b1.ochan), 1);
        tick();
        chk("rr_idle_odv", 32'(b1.odv), 0);

        do_reset();
        obusy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            din = {8'(8'h20 + k), 8'(8'h10 + k)};
            dinv = 2'b11;
            tick();
        end
        dinv = '0;
        obusy = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("fp_odv", 32'(b0.odv), 1);
            chk("fp_od", 32'(b0.od), k < 3 ? 32'h10 + k : 32'h20 + k - 3);
            chk("fp_ochan", 32'(b0.ochan), k < 3 ? 0 : 1);
        end

        do_reset();
        obusy = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            din = {8'h00, 8'(k)};
            dinv = 2'b01;
            tick();
        end
        dinv = '0;
        chk("ovf_set", 32'(b1.ovf), 1);
        chk("ovf_nonempty", 32'(b1.empty[0]), 0);
        obusy = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("ovf_drain_odv", 32'(b1.odv), 1);
            chk("ovf_drain_od", 32'(b1.od), 32'(k));
        end
        tick();
        chk("ovf_drained_odv", 32'(b1.odv), 0);
        ovfclr = 1'b1;
        tick();
        ovfclr = 1'b0;
        chk("ovf_clr", 32'(b1.ovf), 0);

        do_reset();
        obusy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            din = {8'h00, 8'(8'ha0 + k)};
            dinv = 2'b01;
            tick();
        end
        obusy = 1'b0;
        din = 16'h00a4;
        tick();
        dinv = '0;
        chk("full_rw_ovf", 32'(b1.ovf), 1);
        chk("full_rw_od", 32'(b1.od), 32'ha0);
        for (int k = 1; k < 4; k++) begin
            tick();
            chk("full_rw_drain", 32'(b1.od), 32'ha0 + k);
        end
        tick();
        chk("full_rw_end_odv", 32'(b1.odv), 0);

        do_reset();
        obusy = 1'b1;
        din = 16'h5152;
        dinv = 2'b11;
        tick();
        dinv = 2'b01;
        tick();
        dinv = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        obusy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("midrst_odv", 32'(b1.odv), 0);
            chk("midrst_empty", 32'(b1.empty), 3);
        end
        din = 16'h0077;
        dinv = 2'b01;
        tick();
        dinv = '0;
        chk("midrst_wr_empty", 32'(b1.empty), 2);
        tick();
        chk("midrst_wr_odv", 32'(b1.odv), 1);
        chk("midrst_wr_od", 32'(b1.od), 32'h77);

        do_reset();
        obusy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            din = 16'($urandom);
            dinv = 2'b11;
            tick();
        end
        dinv = '0;
        obusy = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rr_alt_odv", 32'(b1.odv), 1);
            chk("rr_alt_ochan", 32'(b1.ochan), 32'(k % 2));
        end

        do_reset();
        for (int n = 0; n < 3000; n++) begin
            din = 16'($urandom);
            dinv = 2'($urandom);
            obusy = $urandom_range(0, 9) < 3;
            ovfclr = $urandom_range(0, 19) == 0;
            reset = $urandom_range(0, 199) == 0;
            tick();
        end
        reset = 1'b0;
        dinv = '0;
        obusy = 1'b0;
        ovfclr = 1'b0;
        for (int n = 0; n < 12; n++) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
